// File: rtl/guess_pkg.sv
// Shared types and constants for the word-guess checker.
//   state_e    : checker FSM states
//   res_code_e : per-position score code (2 bits)
//   WORD_LEN, MAX_ATTEMPTS, ASCII_BS, ASCII_CR
package guess_pkg;

    localparam int unsigned WORD_LEN     = 5;
    localparam int unsigned MAX_ATTEMPTS = 6;

    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StScoreGreen,
        StScoreYellow,
        StReport,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ResAbsent  = 2'd0,
        ResPresent = 2'd1,
        ResCorrect = 2'd2
    } res_code_e;

endpackage

// File: rtl/letter_decoder.sv
// Classifies one received byte (purely combinational).
//   byte_i      : raw ASCII byte
//   is_letter_o : 'A'-'Z' or 'a'-'z'
//   is_bs_o     : backspace
//   is_cr_o     : carriage return (submit)
//   upper_o     : byte with lowercase letters folded to uppercase
module letter_decoder
    import guess_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_letter_o,
    output logic       is_bs_o,
    output logic       is_cr_o,
    output logic [7:0] upper_o
);

    logic is_upper;
    logic is_lower;

    always_comb begin
        is_upper    = (byte_i >= 8'h41) && (byte_i <= 8'h5A);
        is_lower    = (byte_i >= 8'h61) && (byte_i <= 8'h7A);
        is_letter_o = is_upper || is_lower;
        is_bs_o     = (byte_i == ASCII_BS);
        is_cr_o     = (byte_i == ASCII_CR);
        upper_o     = is_lower ? (byte_i - 8'h20) : byte_i;
    end

endmodule

// File: rtl/guess_checker.sv
// Five-letter word guess checker.
// Collects letters from an upstream byte stream, scores a submitted guess against a
// latched secret word (exact matches first, then one position per cycle for misplaced
// letters), and reports result/win/lose with a one-cycle result_valid strobe.
//   clk, rst (async, active-high)
//   guess/guess_valid : input bytes;  new_game : start strobe;  secret_word : 5 ASCII chars
//   game_rdy          : high while collecting letters
//   result            : 2-bit code per position, position 0 in [9:8]
//   result_valid, attempts, win, lose
module guess_checker
    import guess_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  guess,
    input  logic        guess_valid,
    input  logic        new_game,
    input  logic [39:0] secret_word,
    output logic        game_rdy,
    output logic [9:0]  result,
    output logic        result_valid,
    output logic [2:0]  attempts,
    output logic        win,
    output logic        lose
);

    state_e                state_q;
    logic      [7:0]       secret_q  [WORD_LEN];
    logic      [7:0]       letters_q [WORD_LEN];
    res_code_e             codes_q   [WORD_LEN];
    logic      [WORD_LEN-1:0] used_q;
    logic      [2:0]       count_q;
    logic      [2:0]       pos_q;
    logic      [9:0]       result_q;
    logic                  result_valid_q;
    logic      [2:0]       attempts_q;
    logic                  win_q;
    logic                  lose_q;
    logic                  game_rdy_q;

    logic       is_letter, is_bs, is_cr;
    logic [7:0] upper;

    letter_decoder u_dec (
        .byte_i      (guess),
        .is_letter_o (is_letter),
        .is_bs_o     (is_bs),
        .is_cr_o     (is_cr),
        .upper_o     (upper)
    );

    // Misplaced-letter search for the position currently being scored.
    logic                  match_found;
    logic      [2:0]       match_idx;
    res_code_e             codes_upd [WORD_LEN];
    logic      [WORD_LEN-1:0] used_upd;
    logic      [9:0]       res_packed;
    logic                  all_correct;
    logic      [2:0]       attempts_inc;

    always_comb begin
        match_found = 1'b0;
        match_idx   = 3'd0;
        // Descending scan so the lowest matching index wins.
        for (int j = int'(WORD_LEN) - 1; j >= 0; j--) begin
            if (!used_q[j] && (secret_q[j] == letters_q[pos_q])) begin
                match_found = 1'b1;
                match_idx   = 3'(j);
            end
        end

        codes_upd = codes_q;
        used_upd  = used_q;
        if (codes_q[pos_q] != ResCorrect) begin
            if (match_found) begin
                codes_upd[pos_q]    = ResPresent;
                used_upd[match_idx] = 1'b1;
            end else begin
                codes_upd[pos_q] = ResAbsent;
            end
        end

        res_packed  = '0;
        all_correct = 1'b1;
        for (int i = 0; i < int'(WORD_LEN); i++) begin
            res_packed[2*(int'(WORD_LEN)-1-i) +: 2] = codes_upd[i];
            if (codes_upd[i] != ResCorrect) all_correct = 1'b0;
        end

        attempts_inc = attempts_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            used_q         <= '0;
            count_q        <= '0;
            pos_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            attempts_q     <= '0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            game_rdy_q     <= 1'b0;
            for (int i = 0; i < int'(WORD_LEN); i++) begin
                secret_q[i]  <= '0;
                letters_q[i] <= '0;
                codes_q[i]   <= ResAbsent;
            end
        end else begin
            result_valid_q <= 1'b0;
            if (new_game) begin
                for (int i = 0; i < int'(WORD_LEN); i++) begin
                    secret_q[i]  <= secret_word[8*(int'(WORD_LEN)-1-i) +: 8];
                    letters_q[i] <= '0;
                end
                count_q    <= '0;
                attempts_q <= '0;
                win_q      <= 1'b0;
                lose_q     <= 1'b0;
                result_q   <= '0;
                game_rdy_q <= 1'b1;
                state_q    <= StCollect;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StCollect: begin
                        if (guess_valid) begin
                            if (is_letter) begin
                                // Letters beyond the fifth are dropped.
                                if (count_q < 3'(WORD_LEN)) begin
                                    letters_q[count_q] <= upper;
                                    count_q            <= count_q + 3'd1;
                                end
                            end else if (is_bs) begin
                                if (count_q != 3'd0) count_q <= count_q - 3'd1;
                            end else if (is_cr) begin
                                if (count_q == 3'(WORD_LEN)) begin
                                    game_rdy_q <= 1'b0;
                                    state_q    <= StScoreGreen;
                                end
                            end
                        end
                    end
                    StScoreGreen: begin
                        for (int i = 0; i < int'(WORD_LEN); i++) begin
                            if (letters_q[i] == secret_q[i]) begin
                                codes_q[i] <= ResCorrect;
                                used_q[i]  <= 1'b1;
                            end else begin
                                codes_q[i] <= ResAbsent;
                                used_q[i]  <= 1'b0;
                            end
                        end
                        pos_q   <= '0;
                        state_q <= StScoreYellow;
                    end
                    StScoreYellow: begin
                        codes_q <= codes_upd;
                        used_q  <= used_upd;
                        if (pos_q == 3'(WORD_LEN - 1)) begin
                            // Outputs are registered on entry so they are valid in REPORT.
                            result_q       <= res_packed;
                            result_valid_q <= 1'b1;
                            attempts_q     <= attempts_inc;
                            win_q          <= all_correct;
                            lose_q         <= !all_correct &&
                                              (attempts_inc == 3'(MAX_ATTEMPTS));
                            state_q        <= StReport;
                        end else begin
                            pos_q <= pos_q + 3'd1;
                        end
                    end
                    StReport: begin
                        count_q <= '0;
                        if (win_q || lose_q) begin
                            state_q <= StDone;
                        end else begin
                            game_rdy_q <= 1'b1;
                            state_q    <= StCollect;
                        end
                    end
                    StDone: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign game_rdy     = game_rdy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign attempts     = attempts_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: doc/guess_checker.md
GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: guess  input  8  ASCII byte from upstream receive buffer.
REQ-004 SHALL have port: guess_valid  input  1  one-cycle strobe qualifying guess.
REQ-005 SHALL have port: new_game  input  1  one-cycle strobe; starts a game.
REQ-006 SHALL have port: secret_word  input  40  uppercase ASCII; [39:32] = position 0.
REQ-007 SHALL have port: game_rdy  output  1  high only in COLLECT; drives upstream buffer game_rdy.
REQ-008 SHALL have port: result  output  10  2 bits per position; [9:8] = position 0; codes ABSENT=0, PRESENT=1, CORRECT=2.
REQ-009 SHALL have port: result_valid  output  1  one-cycle strobe; result, win, lose valid.
REQ-010 SHALL have port: attempts  output  3  submitted guesses this game, 0..6.
REQ-011 SHALL have port: win  output  1  level; all five positions CORRECT.
REQ-012 SHALL have port: lose  output  1  level; six guesses submitted, no win.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, SCORE_GREEN, SCORE_YELLOW, REPORT, DONE.
REQ-014 SHALL on new_game in any state: latch secret_word, clear letters/attempts/win/lose, go COLLECT next cycle; new_game beats simultaneous guess_valid.
REQ-015 SHALL in COLLECT accept letters 'A'-'Z' and 'a'-'z' (lowercase folded to uppercase) into next slot while fewer than 5 stored; 6th letter dropped.
REQ-016 SHALL treat 0x08 as backspace: decrement letter count; ignored at count 0.
REQ-017 SHALL treat 0x0D as submit: with count 5 go SCORE_GREEN; with count <5 ignore.
REQ-018 SHALL ignore all other bytes, and any guess_valid outside COLLECT.
REQ-019 SHALL in SCORE_GREEN (1 cycle) mark CORRECT where guess[i]==secret[i] and mark those secret positions used.
REQ-020 SHALL in SCORE_YELLOW (5 cycles, position i = 0..4, one per cycle) mark non-CORRECT position i PRESENT if some unused secret position j matches (lowest j), then mark j used; else ABSENT.
REQ-021 SHALL in REPORT (1 cycle) drive result_valid=1, increment attempts, set win if all CORRECT, set lose if attempts becomes 6 without win.
REQ-022 SHALL go from REPORT to DONE if win or lose, else to COLLECT with letter count cleared.
REQ-023 SHALL give latency: submit strobe at edge N -> result_valid high in cycle N+7.
REQ-024 SHALL hold result stable from REPORT until next REPORT or new_game.
REQ-025 SHALL remain in DONE with win/lose held until new_game.

Reset
REQ-026 SHALL on rst asynchronously enter IDLE; result=0, result_valid=0, attempts=0, win=0, lose=0, game_rdy=0, letter count 0, latched secret 0.
REQ-027 SHALL abort any in-progress scoring on rst with no result_valid emitted.
REQ-028 SHALL leave IDLE only on new_game.

Structure
REQ-029 SHALL take from shared package guess_pkg: state enum, result code enum, WORD_LEN=5, MAX_ATTEMPTS=6, ASCII_BS=0x08, ASCII_CR=0x0D.
REQ-030 SHALL use one sub-module letter_decoder: byte -> {is_letter, is_bs, is_cr, upper_ascii}, purely combinational.

Verification
REQ-031 SHALL cover: secret "CRANE", bytes "crane",0x0D -> result=all CORRECT (0x2AA), win=1, attempts=1, state DONE, 7 cycles after CR.
REQ-032 SHALL cover: secret "CRANE", "NACER",0x0D -> all PRESENT (0x155), win=0, back to COLLECT, game_rdy=1.
REQ-033 SHALL cover: secret "APPLE", "PPPPP",0x0D -> ABSENT,CORRECT,CORRECT,ABSENT,ABSENT (0x0A0).
REQ-034 SHALL cover: "CRANX",0x08,"E","Q",0x0D with secret "CRANE" -> Q dropped, all CORRECT; CR after 4 letters ignored.
REQ-035 SHALL cover: six wrong guesses -> lose=1 on 6th REPORT, attempts=6, further bytes ignored until new_game.
REQ-036 SHALL cover: rst asserted during SCORE_YELLOW -> IDLE immediately, no result_valid, all outputs 0.
